// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA timing receiver that measures line/frame totals, tracks raster lock and recovers x/y.
// Optional active-pixel frame CRC is built when VGA_RX_CRC_EN is defined.
module vga_sync_rx #(
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  input  logic [5:0]    rgb,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          de_o,
  output logic          line_start,
  output logic          frame_start,
  output logic [HW-1:0] h_total,
  output logic [VW-1:0] v_total,
  output logic          locked,
  output logic          err,
  output logic [15:0]   frame_crc
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam logic POL = 1'(SYNC_POL);
  state_t state, state_n;
  logic hs_r, vs_r, hs_p, vs_p, de_r, hs_e, vs_e, to, line_act;
  logic h_first, h_first_n, h_bad, h_bad_n, h_bad_now;
  logic [HW-1:0] h_cnt, per, h_total_n;
  logic [VW-1:0] v_cnt, frame, v_total_n;
  logic [3:0] match_cnt, match_n;
  assign hs_e        = hs_r & ~hs_p;
  assign vs_e        = vs_r & ~vs_p;
  assign line_start  = hs_e;
  assign frame_start = vs_e;
  assign de_o        = de_r;
  assign per         = &h_cnt ? h_cnt : h_cnt + 1'b1;
  assign frame       = &v_cnt ? v_cnt : v_cnt + VW'(hs_e);
  assign to          = &h_cnt & ~hs_e;
  assign h_bad_now   = h_bad | (hs_e & ~h_first & (per != h_total));
  assign locked      = state_n == LOCKED;
  always_comb begin
    state_n   = state;
    h_total_n = h_total;
    v_total_n = v_total;
    match_n   = match_cnt;
    h_bad_n   = h_bad;
    h_first_n = h_first;
    err       = 1'b0;
    case (state)
      SEARCH: if (vs_e && !to) begin
        // first measured frame must always become the new reference
        state_n   = MEASURE;
        h_bad_n   = 1'b1;
        h_first_n = 1'b1;
        match_n   = '0;
      end
      MEASURE: begin
        if (hs_e) begin
          h_total_n = per;
          h_first_n = 1'b0;
          h_bad_n   = h_bad_now;
        end
        if (vs_e) begin
          h_bad_n   = 1'b0;
          h_first_n = 1'b1;
          if (frame == v_total && !h_bad_now) begin
            match_n = match_cnt + 4'd1;
            // the reference frame counts as the first of LOCK_FRAMES
            if (match_n >= 4'(LOCK_FRAMES - 1)) state_n = LOCKED;
          end else begin
            v_total_n = frame;
            match_n   = '0;
          end
        end
        if (to) state_n = SEARCH;
      end
      LOCKED: if ((hs_e && per != h_total) || (vs_e && frame != v_total) || to) begin
        err     = 1'b1;
        state_n = SEARCH;
      end
      default: state_n = SEARCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      hs_p      <= 1'b0;
      vs_p      <= 1'b0;
      de_r      <= 1'b0;
      state     <= SEARCH;
      h_cnt     <= '0;
      v_cnt     <= '0;
      h_total   <= '0;
      v_total   <= '0;
      match_cnt <= '0;
      h_bad     <= 1'b0;
      h_first   <= 1'b0;
      line_act  <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else begin
      hs_r      <= hsync == POL;
      vs_r      <= vsync == POL;
      hs_p      <= hs_r;
      vs_p      <= vs_r;
      de_r      <= de;
      state     <= state_n;
      h_cnt     <= hs_e ? '0 : per;
      v_cnt     <= vs_e ? '0 : frame;
      h_total   <= h_total_n;
      v_total   <= v_total_n;
      match_cnt <= match_n;
      h_bad     <= h_bad_n;
      h_first   <= h_first_n;
      line_act  <= hs_e ? 1'b0 : line_act | de_r;
      x         <= hs_e ? '0 : de_r ? x + 10'd1 : x;
      y         <= vs_e ? '0 : (hs_e && line_act) ? y + 10'd1 : y;
    end
`ifdef VGA_RX_CRC_EN
  logic [5:0] rgb_r;
  logic [15:0] crc;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rgb_r     <= '0;
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      rgb_r     <= rgb;
      crc       <= vs_e ? 16'hFFFF : de_r ? crc_step(crc, {2'b00, rgb_r}) : crc;
      frame_crc <= vs_e ? crc : frame_crc;
    end
`else
  logic [5:0] unused_rgb;
  assign unused_rgb = rgb;
  assign frame_crc  = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx on a reduced 40x20 raster with active-low syncs.
module tb_vga_sync_rx;
  localparam int HT = 40, HA = 32, HS0 = 34, HS1 = 38, VT = 20, VA = 16, VS0 = 17, VS1 = 19;
  logic clk = 0, rst_n = 0, hsync = 1, vsync = 1, de = 0;
  logic [5:0] rgb = 6'h3F;
  logic [9:0] x, y;
  logic de_o, line_start, frame_start, locked, err;
  logic [10:0] h_total;
  logic [9:0] v_total;
  logic [15:0] frame_crc;
  typedef struct packed {logic err; logic lock;} hev_t;
  typedef struct packed {logic lock; logic ls; logic [15:0] crc;} vev_t;
  hev_t hq[$];
  vev_t vq[$];
  int n_cmp = 0, n_bad = 0, err_cnt = 0, strobe_cnt = 0, xmax = 0, ymax = 0, fc = 0;
  bit mlock = 0, hp = 0, vp = 0;
  logic [15:0] cur = 16'hFFFF, last = 16'h0000;
  vga_sync_rx dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .x(x), .y(y), .de_o(de_o), .line_start(line_start), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total), .locked(locked), .err(err), .frame_crc(frame_crc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? (r << 1) ^ 16'h1021 : r << 1;
    return r;
  endfunction
  task automatic zero_chk(input string tg);
    chk({tg, "_x"}, x, 0);
    chk({tg, "_y"}, y, 0);
    chk({tg, "_de"}, de_o, 0);
    chk({tg, "_ls"}, line_start, 0);
    chk({tg, "_fs"}, frame_start, 0);
    chk({tg, "_ht"}, h_total, 0);
    chk({tg, "_vt"}, v_total, 0);
    chk({tg, "_lock"}, locked, 0);
    chk({tg, "_err"}, err, 0);
    chk({tg, "_crc"}, frame_crc, 0);
  endtask
  task automatic pix(input bit h, input bit v, input bit d, input bit st);
    @(posedge clk);
    #2;
    if (v && !vp) begin
      fc++;
      if (fc >= 3) mlock = 1;
`ifdef VGA_RX_CRC_EN
      vq.push_back(vev_t'{lock: mlock, ls: h && !hp, crc: last});
`else
      vq.push_back(vev_t'{lock: mlock, ls: h && !hp, crc: 16'h0000});
`endif
      last = cur;
      cur = 16'hFFFF;
    end
    if (h && !hp) begin
      if (st && mlock) begin
        hq.push_back(hev_t'{err: 1'b1, lock: 1'b0});
        mlock = 0;
        fc = 0;
      end else hq.push_back(hev_t'{err: 1'b0, lock: mlock});
    end
    if (d) cur = crc_byte(cur, {2'b00, rgb});
    hsync = ~h;
    vsync = ~v;
    de = d;
    hp = h;
    vp = v;
  endtask
  task automatic frame(input int st_line, input bit simul, input int stop_line);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == st_line) ? HT + 1 : HT;
      for (int p = 0; p < len; p++) begin
        bit h, v, d;
        if (l == stop_line && p == HS0 - 1) return;
        h = p >= HS0 + len - HT && p < HS1 + len - HT;
        v = simul ? ((l == VS0 && p >= HS0) || (l > VS0 && l < VS1) || (l == VS1 && p < HS0))
                  : (l >= VS0 && l < VS1);
        d = l < VA && p < HA;
        pix(h, v, d, l == st_line);
      end
    end
  endtask
  always @(negedge clk)
    if (!rst_n) begin
      xmax = 0;
      ymax = 0;
    end else begin
      hev_t he;
      vev_t ve;
      if (de_o) begin
        if (int'(x) > xmax) xmax = int'(x);
        if (int'(y) > ymax) ymax = int'(y);
      end
      if (err) err_cnt++;
      if (line_start || frame_start) strobe_cnt++;
      if (line_start) begin
        chk("ls_expected", hq.size() > 0, 1);
        if (hq.size() > 0) begin
          he = hq.pop_front();
          chk("ls_err", err, he.err);
          chk("ls_lock", locked, he.lock);
        end
      end
      if (frame_start) begin
        chk("fs_expected", vq.size() > 0, 1);
        if (vq.size() > 0) begin
          ve = vq.pop_front();
          chk("fs_lock", locked, ve.lock);
          chk("fs_ls", line_start, ve.ls);
          chk("fs_err", err, 0);
          chk("fs_crc", frame_crc, ve.crc);
          chk("fs_xmax", xmax, HA - 1);
          chk("fs_ymax", ymax, VA - 1);
          if (ve.lock) begin
            chk("fs_htot", h_total, HT);
            chk("fs_vtot", v_total, VT);
          end
        end
        xmax = 0;
        ymax = 0;
      end
    end
  initial begin
    int e0, s0;
    #23;
    zero_chk("rst");
    @(posedge clk);
    #2 rst_n = 1;
    repeat (4) frame(-1, 0, -1);
    frame(5, 0, -1);
    repeat (3) frame(-1, 0, -1);
    e0 = err_cnt;
    s0 = strobe_cnt;
    repeat (2060) pix(0, 0, 0, 0);
    @(negedge clk);
    chk("to_err", err_cnt - e0, 1);
    chk("to_strobe", strobe_cnt - s0, 0);
    chk("to_lock", locked, 0);
    mlock = 0;
    fc = 0;
    repeat (3) frame(-1, 0, -1);
    chk("rst_pre_lock", locked, 1);
    frame(-1, 0, 8);
    chk("rst_q", hq.size() + vq.size(), 0);
    #1 rst_n = 0;
    #1 zero_chk("arst");
    mlock = 0;
    fc = 0;
    last = 16'h0000;
    cur = 16'hFFFF;
    hsync = 1;
    vsync = 1;
    de = 0;
    hp = 0;
    vp = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (4) frame(-1, 1, -1);
    repeat (4) pix(0, 0, 0, 0);
    @(negedge clk);
    chk("end_q", hq.size() + vq.size(), 0);
    chk("err_total", err_cnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
